ifetch: RTL
===========

// Module: ifetch
// PURPOSE
//  Instruction fetch stage of the eBPF softcore; sits directly upstream of the instruction register.
//  Holds the PC and issues 64-bit reads to instruction memory over a req/ack handshake.
//  Assembles one eBPF instruction, or two slots for lddw (opcode 8'h18), and presents it on ir_out with an ir_load strobe.
// PARAMETERS
//  ADDR_W   16      PC / imem address width, in 64-bit instruction slots
//  LDDW_OP  8'h18   opcode byte that marks a two-slot (wide) instruction
// PORTS
//  clk          in   1       clock, all state on rising edge
//  nrst         in   1       synchronous active-low reset
//  fetch_req    in   1       controller requests the next instruction; sampled only in IDLE
//  pc_load      in   1       load PC with pc_load_val; accepted only in IDLE
//  pc_load_val  in   ADDR_W  absolute jump target (slot index)
//  imem_req     out  1       memory read request
//  imem_addr    out  ADDR_W  memory read address
//  imem_ack     in   1       read data valid this cycle; may arrive in the same cycle as imem_req
//  imem_rdata   in   64      read data
//  ir_out       out  64      fetched instruction (first slot), feeds the IR bus
//  ir_load      out  1       one-cycle strobe: ir_out/imm_hi/wide valid and new
//  imm_hi       out  32      lddw upper immediate = second-slot imem_rdata[63:32]; 0 if not wide
//  wide         out  1       last instruction was a two-slot lddw
//  ill_wide     out  1       lddw second slot had a nonzero opcode byte; valid with ir_load
//  busy         out  1       fetch in progress (state != IDLE)
//  pc           out  ADDR_W  address of the next instruction to fetch
// BEHAVIOUR
//  Reset (nrst=0 at edge): state=IDLE; pc=0.
//   imem_req, ir_load, wide and ill_wide are 0; imm_hi=0; ir_out=64'h0; imem_addr=0.
//  Reset mid-fetch: abandons the transaction; imem_req=0 from the next cycle; no ir_load.
//  States: IDLE, WAIT1, WAIT2.
//  IDLE:
//   - pc_load=1: pc <= pc_load_val.
//   - fetch_req=1: imem_addr <= (pc_load ? pc_load_val : pc); imem_req <= 1; -> WAIT1.
//   - pc_load and fetch_req in the same cycle: the fetch uses pc_load_val.
//  WAIT1: imem_req and imem_addr held stable until imem_ack=1. On ack:
//   - ir_out <= imem_rdata.
//   - Opcode imem_rdata[7:0] != LDDW_OP: ir_load <= 1, wide <= 0, imm_hi <= 0, ill_wide <= 0;
//     pc <= pc+1; imem_req <= 0; -> IDLE.
//   - Opcode == LDDW_OP: imem_addr <= pc+1; imem_req stays 1; -> WAIT2.
//  WAIT2: hold until imem_ack=1. On ack:
//   - imm_hi <= imem_rdata[63:32]; ill_wide <= (imem_rdata[7:0] != 0); wide <= 1; ir_load <= 1;
//   - pc <= pc+2; imem_req <= 0; -> IDLE.
//  ir_load is high for exactly one cycle per instruction; ir_out/imm_hi/wide/ill_wide hold until the next ir_load.
//  Latency, zero-wait memory: fetch_req in cycle 0 -> imem_req in cycle 1 -> ir_load in cycle 2 (lddw: cycle 3).
//  Every ack spends one cycle: one cycle with imem_ack=1 completes one slot.
//  fetch_req and pc_load while busy=1 are ignored; no queuing.
//  imem_ack while imem_req=0 is ignored.
//  PC arithmetic is modulo 2^ADDR_W:
//   - lddw at pc = 2^ADDR_W-1 reads its second slot from 0.
//   - pc then wraps to 1; no error.
//  busy = (state != IDLE), registered with the state.
// TESTING
//  1. Reset; mem[0]=64'h0000002A_00000107; fetch_req at cycle 0 with same-cycle ack.
//     -> imem_addr=0 in cycle 1; ir_load=1 in cycle 2; ir_out=mem[0]; wide=0; pc=1.
//  2. pc=1; mem[1]=64'h89ABCDEF_00000118; mem[2]=64'h01234567_00000000.
//     -> addrs 1 then 2; a single ir_load; ir_out=mem[1]; imm_hi=32'h01234567; wide=1; ill_wide=0; pc=3.
//  3. Ack delayed 3 cycles per slot.
//     -> imem_req/imem_addr stable across every wait cycle; exactly one ir_load; busy high throughout.
//  4. pc_load=1 with pc_load_val=16'h00F0 and fetch_req=1 in the same cycle.
//     -> imem_addr=16'h00F0; pc=16'h00F1 after.
//     Then pc_load=16'h0005 while busy -> ignored; pc unchanged.
//  5. pc=16'hFFFF, lddw whose second slot has opcode 8'h07.
//     -> addrs FFFF then 0000; pc=16'h0001; wide=1; ill_wide=1.
//  6. nrst=0 in WAIT1 with ack pending; ack asserted the cycle after reset.
//     -> imem_req=0; no ir_load; pc=0; state stays IDLE.

Source files
------------

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// ifetch_if : instruction-memory read bus (req/ack, 64-bit slots)  | rev 1.0
// ============================================================================
interface ifetch_if #(
   parameter int ADDR_W = 16
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [63:0]       imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// ifetch : eBPF fetch stage, one- or two-slot (lddw) instruction assembly | rev 1.0
// ============================================================================
module ifetch #(
   parameter int          ADDR_W  = 16,
   parameter logic [7:0]  LDDW_OP = 8'h18
) (
   input  wire logic              clk,
   input  wire logic              nrst,
   ifetch_if.master               imem,
   input  wire logic              fetch_req,
   input  wire logic              pc_load,
   input  wire logic [ADDR_W-1:0] pc_load_val,
   output logic [63:0]            ir_out,
   output logic                   ir_load,
   output logic [31:0]            imm_hi,
   output logic                   wide,
   output logic                   ill_wide,
   output logic                   busy,
   output logic [ADDR_W-1:0]      pc
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT1 = 2'd1,
      S_WAIT2 = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] pc_q,      pc_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic              req_q,     req_d;
   logic [63:0]       ir_q,      ir_d;
   logic [31:0]       imm_hi_q,  imm_hi_d;
   logic              wide_q,    wide_d;
   logic              ill_q,     ill_d;
   logic              ir_load_q, ir_load_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      req_d     = req_q;
      ir_d      = ir_q;
      imm_hi_d  = imm_hi_q;
      wide_d    = wide_q;
      ill_d     = ill_q;
      ir_load_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pc_load) pc_d = pc_load_val;
            if (fetch_req) begin
               addr_d  = pc_load ? pc_load_val : pc_q;
               req_d   = 1'b1;
               state_d = S_WAIT1;
            end
         end
         S_WAIT1: begin
            if (imem.imem_ack) begin
               ir_d = imem.imem_rdata;
               if (imem.imem_rdata[7:0] != LDDW_OP) begin
                  ir_load_d = 1'b1;
                  wide_d    = 1'b0;
                  imm_hi_d  = 32'h0;
                  ill_d     = 1'b0;
                  pc_d      = pc_q + ADDR_W'(1);
                  req_d     = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  // pc still points at the first slot; second slot follows it (wraps at top)
                  addr_d  = pc_q + ADDR_W'(1);
                  state_d = S_WAIT2;
               end
            end
         end
         S_WAIT2: begin
            if (imem.imem_ack) begin
               imm_hi_d  = imem.imem_rdata[63:32];
               ill_d     = (imem.imem_rdata[7:0] != 8'h00);
               wide_d    = 1'b1;
               ir_load_d = 1'b1;
               pc_d      = pc_q + ADDR_W'(2);
               req_d     = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         addr_q    <= '0;
         req_q     <= 1'b0;
         ir_q      <= 64'h0;
         imm_hi_q  <= 32'h0;
         wide_q    <= 1'b0;
         ill_q     <= 1'b0;
         ir_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         ir_q      <= ir_d;
         imm_hi_q  <= imm_hi_d;
         wide_q    <= wide_d;
         ill_q     <= ill_d;
         ir_load_q <= ir_load_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign ir_out         = ir_q;
   assign ir_load        = ir_load_q;
   assign imm_hi         = imm_hi_q;
   assign wide           = wide_q;
   assign ill_wide       = ill_q;
   assign busy           = (state_q != S_IDLE);
   assign pc             = pc_q;

endmodule

`default_nettype wire
